// File: rtl/dmem_bus_bridge_if.sv
// Data-memory bus between the MEM-stage bridge (master) and the external memory (slave).
// The request uses a valid/ready handshake, and the response is a single-cycle valid pulse.
interface dmem_bus_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges MEM-stage loads/stores onto a variable-latency data bus, stalling the pipeline
// until the access completes; handles byte lanes, load extension and timeout abort.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          WAIT_WR_RSP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [2:0]        core_fun3,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic              core_misaligned,
  output logic              core_bus_err,
  dmem_bus_bridge_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // cnt_q holds completed wait cycles; abort at the end of the TIMEOUT-th one
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [2:0]  fun3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req;
  logic        we_in;
  logic        misal;
  logic        timed_out;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  assign req       = core_rd | core_wr;
  assign we_in     = core_wr & ~core_rd;
  assign timed_out = (cnt_q >= TO_LAST);

  always_comb begin
    misal      = 1'b0;
    lane_wdata = core_wdata;
    lane_wstrb = 4'b1111;
    case (core_fun3[1:0])
      2'b00: begin
        lane_wdata = {4{core_wdata[7:0]}};
        lane_wstrb = 4'b0001 << core_addr[1:0];
      end
      2'b01: begin
        misal      = core_addr[0];
        lane_wdata = {2{core_wdata[15:0]}};
        lane_wstrb = 4'b0011 << core_addr[1:0];
      end
      default: misal = |core_addr[1:0];
    endcase
  end

  always_comb begin
    sel_byte = 8'(rdata_q >> {addr_q[1:0], 3'b000});
    sel_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (fun3_q)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'h000000, sel_byte};
      3'b101:  load_ext = {16'h0000, sel_half};
      default: load_ext = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      fun3_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && !misal) begin
            state_q <= S_REQ;
            cnt_q   <= '0;
            addr_q  <= core_addr;
            wdata_q <= we_in ? lane_wdata : '0;
            wstrb_q <= we_in ? lane_wstrb : '0;
            we_q    <= we_in;
            fun3_q  <= core_fun3;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.bus_req_ready) begin
            state_q <= (we_q && !WAIT_WR_RSP) ? S_DONE : S_RESP;
          end else if (timed_out) begin
            state_q <= S_DONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RESP: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.bus_rsp_valid) begin
            state_q <= S_DONE;
            rdata_q <= bus.bus_rsp_rdata;
          end else if (timed_out) begin
            state_q <= S_DONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks from an aborted access
  always_comb begin
    core_rdata        = '0;
    core_stall        = 1'b0;
    core_misaligned   = 1'b0;
    core_bus_err      = 1'b0;
    bus.bus_req_valid = 1'b0;
    bus.bus_we        = 1'b0;
    bus.bus_addr      = '0;
    bus.bus_wdata     = '0;
    bus.bus_wstrb     = '0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          core_stall      = req & ~misal;
          core_misaligned = req & misal;
        end
        S_REQ: begin
          core_stall        = 1'b1;
          bus.bus_req_valid = 1'b1;
          bus.bus_we        = we_q;
          bus.bus_addr      = {addr_q[31:2], 2'b00};
          bus.bus_wdata     = wdata_q;
          bus.bus_wstrb     = wstrb_q;
        end
        S_RESP: core_stall = 1'b1;
        default: begin
          core_rdata   = we_q ? '0 : load_ext;
          core_bus_err = err_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: a bus responder with programmable ready/response delays,
// and a scoreboard of expected completions checked when each access reaches its DONE cycle.
module tb_dmem_bus_bridge;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    int          valids;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  wstrb;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_rd, core_wr;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_fun3;
  logic [31:0] core_rdata;
  logic        core_stall, core_misaligned, core_bus_err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  int          rdy_wait    = 0;
  int          rsp_wait    = 0;
  bit          never_ready = 1'b0;
  logic [31:0] rsp_word    = '0;
  int          abort_gen   = 0;
  int          pend_gen    = 0;
  bit          pend        = 1'b0;
  int          vcnt        = 0;
  int          rcnt        = 0;

  dmem_bus_bridge_if bus ();

  dmem_bus_bridge #(.TIMEOUT(4), .WAIT_WR_RSP(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_rd         (core_rd),
    .core_wr         (core_wr),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_fun3       (core_fun3),
    .core_rdata      (core_rdata),
    .core_stall      (core_stall),
    .core_misaligned (core_misaligned),
    .core_bus_err    (core_bus_err),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Memory responder: acts mid-cycle so its outputs are stable at the next rising edge
  initial begin
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.bus_rsp_valid = 1'b0;
      if (bus.bus_req_valid) begin
        if (!never_ready && vcnt >= rdy_wait) begin
          bus.bus_req_ready = 1'b1;
          pend = 1'b1; rcnt = 0; vcnt = 0; pend_gen = abort_gen;
        end else begin
          bus.bus_req_ready = 1'b0;
          vcnt++;
        end
      end else begin
        bus.bus_req_ready = 1'b0;
        vcnt = 0;
        if (pend && pend_gen == abort_gen) begin
          if (rcnt >= rsp_wait) begin
            bus.bus_rsp_valid = 1'b1;
            bus.bus_rsp_rdata = rsp_word;
            pend = 1'b0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ex(input logic [31:0] rdata, input logic err, input int waits,
                              input int valids, input logic [31:0] baddr,
                              input logic [31:0] bwdata, input logic [3:0] wstrb, input logic we);
    exp_t e;
    e.rdata = rdata; e.err = err; e.waits = waits; e.valids = valids;
    e.baddr = baddr; e.bwdata = bwdata; e.wstrb = wstrb; e.we = we;
    return e;
  endfunction

  task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input exp_t e);
    exp_t        g;
    int          waits  = 0;
    int          valids = 0;
    logic [31:0] ba = '0, bw = '0;
    logic [3:0]  bs = '0;
    logic        bwe = 1'b0;
    logic        done = 1'b0;
    @(posedge clk); #1;
    core_rd = rd; core_wr = wr; core_addr = addr; core_wdata = wdata; core_fun3 = f3;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, ".issue_stall"}, {31'b0, core_stall}, 32'd1);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!core_stall) begin
        done = 1'b1;
      end else begin
        waits++;
        if (bus.bus_req_valid) begin
          if (valids == 0) begin
            ba = bus.bus_addr; bw = bus.bus_wdata; bs = bus.bus_wstrb; bwe = bus.bus_we;
          end
          valids++;
        end
      end
    end
    chk({tag, ".done_reached"}, {31'b0, done}, 32'd1);
    g = sb.pop_front();
    chk({tag, ".rdata"},  core_rdata, g.rdata);
    chk({tag, ".bus_err"}, {31'b0, core_bus_err}, {31'b0, g.err});
    chk({tag, ".waits"},  32'(waits), 32'(g.waits));
    chk({tag, ".valids"}, 32'(valids), 32'(g.valids));
    chk({tag, ".addr"},   ba, g.baddr);
    chk({tag, ".wdata"},  bw, g.bwdata);
    chk({tag, ".wstrb"},  {28'b0, bs}, {28'b0, g.wstrb});
    chk({tag, ".we"},     {31'b0, bwe}, {31'b0, g.we});
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    core_rd = 1'b0; core_wr = 1'b0;
  endtask

  task automatic quiet_checks(input string tag);
    @(negedge clk);
    chk({tag, ".stall"}, {31'b0, core_stall}, 32'd0);
    chk({tag, ".valid"}, {31'b0, bus.bus_req_valid}, 32'd0);
    chk({tag, ".rdata"}, core_rdata, 32'd0);
    chk({tag, ".err"},   {31'b0, core_bus_err}, 32'd0);
    chk({tag, ".mis"},   {31'b0, core_misaligned}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; core_rd = 1'b0; core_wr = 1'b0;
    core_addr = '0; core_wdata = '0; core_fun3 = '0;
    repeat (2) @(posedge clk);
    quiet_checks("reset");
    chk("reset.wstrb", {28'b0, bus.bus_wstrb}, 32'd0);
    chk("reset.addr",  bus.bus_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Minimum latency signed byte load from the top lane
    rdy_wait = 0; rsp_wait = 0; rsp_word = 32'h80112233;
    access("lb", 1, 0, 32'h103, 32'h0, 3'b000, ex(32'hFFFFFF80, 0, 2, 1, 32'h100, 0, 4'b0000, 0));
    rsp_word = 32'h00000000;
    access("sh", 0, 1, 32'h1236, 32'h0000BEEF, 3'b001, ex(0, 0, 2, 1, 32'h1234, 32'hBEEFBEEF, 4'b1100, 1));
    go_idle();

    @(posedge clk); #1;
    core_rd = 1'b1; core_addr = 32'h1001; core_fun3 = 3'b010;
    @(negedge clk);
    chk("misal.pulse", {31'b0, core_misaligned}, 32'd1);
    chk("misal.stall", {31'b0, core_stall}, 32'd0);
    chk("misal.valid", {31'b0, bus.bus_req_valid}, 32'd0);
    go_idle();
    repeat (3) quiet_checks("misal_after");

    rdy_wait = 3; rsp_word = 32'hABCD0000;
    access("lhu", 1, 0, 32'h2002, 32'h0, 3'b101, ex(32'h0000ABCD, 0, 5, 4, 32'h2000, 0, 4'b0000, 0));
    rdy_wait = 0;
    rsp_word = 32'h00007F00;
    access("lb_pos", 1, 0, 32'h201, 32'h0, 3'b000, ex(32'h0000007F, 0, 2, 1, 32'h200, 0, 4'b0000, 0));
    rsp_word = 32'h00FE0000;
    access("lbu", 1, 0, 32'h102, 32'h0, 3'b100, ex(32'h000000FE, 0, 2, 1, 32'h100, 0, 4'b0000, 0));
    rsp_word = 32'h80010000; rsp_wait = 2;
    access("lh", 1, 0, 32'h402, 32'h0, 3'b001, ex(32'hFFFF8001, 0, 4, 1, 32'h400, 0, 4'b0000, 0));
    rsp_wait = 0; rsp_word = 32'h0;
    access("sb", 0, 1, 32'h501, 32'h123456A5, 3'b000, ex(0, 0, 2, 1, 32'h500, 32'hA5A5A5A5, 4'b0010, 1));
    access("sw", 0, 1, 32'h600, 32'hCAFEF00D, 3'b010, ex(0, 0, 2, 1, 32'h600, 32'hCAFEF00D, 4'b1111, 1));
    access("s11", 0, 1, 32'hA00, 32'h01020304, 3'b011, ex(0, 0, 2, 1, 32'hA00, 32'h01020304, 4'b1111, 1));
    rsp_word = 32'hDEADBEEF;
    access("rd_wins", 1, 1, 32'h700, 32'h55555555, 3'b010, ex(32'hDEADBEEF, 0, 2, 1, 32'h700, 0, 4'b0000, 0));
    rsp_word = 32'h89ABCDEF;
    access("ld110", 1, 0, 32'h904, 32'h0, 3'b110, ex(32'h89ABCDEF, 0, 2, 1, 32'h904, 0, 4'b0000, 0));

    never_ready = 1'b1; rsp_word = 32'h12345678;
    access("to_req", 1, 0, 32'h3000, 32'h0, 3'b010, ex(0, 1, 4, 4, 32'h3000, 0, 4'b0000, 0));
    never_ready = 1'b0;
    go_idle();
    quiet_checks("to_req_after");

    rsp_wait = 20;
    access("to_resp", 1, 0, 32'h3100, 32'h0, 3'b010, ex(0, 1, 4, 1, 32'h3100, 0, 4'b0000, 0));
    abort_gen++;
    go_idle();
    quiet_checks("to_resp_after");

    // Reset lands while the response is outstanding; the late response must be ignored
    rsp_wait = 3; rsp_word = 32'h11112222;
    @(posedge clk); #1;
    core_rd = 1'b1; core_addr = 32'h800; core_fun3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    chk("rst_resp.req_valid", {31'b0, bus.bus_req_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; core_rd = 1'b0;
    quiet_checks("rst_resp.in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) quiet_checks("rst_resp.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
